// File: rtl/rm_ioq_hdr_if.sv
// Word-stream bundle between the output queue read side, the header stripper and the tx interface.
interface rm_ioq_hdr_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [CTRL_WIDTH-1:0] in_ctrl;
  logic                  in_wr;
  logic                  in_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;

  modport slave (
    input  in_data, in_ctrl, in_wr, out_rdy,
    output in_rdy, out_data, out_ctrl, out_wr
  );

  modport master (
    output in_data, in_ctrl, in_wr, out_rdy,
    input  in_rdy, out_data, out_ctrl, out_wr
  );
endinterface

// File: rtl/rm_ioq_hdr.sv
// Strips module header words, checks the IOQ length header and forwards payload; >=1 cycle latency.
// Backpressure: 2-entry output buffer, in_rdy is registered and drops as soon as the buffer fills.
module rm_ioq_hdr #(
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = 'hff
) (
  input  logic               clk,
  input  logic               reset,
  rm_ioq_hdr_if.slave        io,
  output logic               pkt_done,
  output logic               len_err,
  output logic               hdr_missing,
  output logic [15:0]        src_port
);
  localparam int BW = 11;
  localparam int WW = 8;

  typedef enum logic {S_HDR, S_PKT} state_e;

  typedef struct packed {
    logic                  miss;
    logic                  err;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  function automatic logic [BW-1:0] sat_add(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BW] ? {BW{1'b1}} : s[BW-1:0];
  endfunction

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  // Byte count of the last word; non-one-hot masks yield 0 and are flagged separately.
  function automatic logic [BW-1:0] last_bytes(input logic [CTRL_WIDTH-1:0] m);
    logic [BW-1:0] n;
    n = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (m == (CTRL_WIDTH'(1) << i)) n = BW'(CTRL_WIDTH - i);
    end
    return n;
  endfunction

  state_e        state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]   hdr_byte_q, hdr_byte_d;
  logic [15:0]   hdr_word_q, hdr_word_d;
  logic [15:0]   src_port_q, src_port_d;
  logic          hdr_vld_q, hdr_vld_d;

  entry_t        mem_q [2];
  entry_t        push_entry, head;
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          in_rdy_q;
  logic          wr_acc, push, pop, mismatch;
  logic [BW-1:0] byte_body, byte_last;
  logic [WW-1:0] word_inc;

  assign io.in_rdy = in_rdy_q && !reset;
  assign wr_acc    = io.in_wr && io.in_rdy;

  assign word_inc  = sat_inc(word_cnt_q);
  assign byte_body = sat_add(byte_cnt_q, BW'(CTRL_WIDTH));
  assign byte_last = sat_add(byte_cnt_q, last_bytes(io.in_ctrl));
  // A saturated counter can never be trusted to match, so it counts as a mismatch.
  assign mismatch  = (16'(byte_last) != hdr_byte_q) || (16'(word_inc) != hdr_word_q) ||
                     !$onehot(io.in_ctrl) || (&byte_last) || (&word_inc);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    hdr_byte_d = hdr_byte_q;
    hdr_word_d = hdr_word_q;
    src_port_d = src_port_q;
    hdr_vld_d  = hdr_vld_q;
    push       = 1'b0;
    push_entry = '{miss: 1'b0, err: 1'b0, ctrl: io.in_ctrl, data: io.in_data};
    case (state_q)
      S_HDR: begin
        if (wr_acc) begin
          if (io.in_ctrl != '0) begin
            if (io.in_ctrl == IOQ_STAGE_NUM) begin
              hdr_byte_d = io.in_data[15:0];
              src_port_d = io.in_data[31:16];
              hdr_word_d = io.in_data[47:32];
              hdr_vld_d  = 1'b1;
            end
          end else begin
            push       = 1'b1;
            word_cnt_d = WW'(1);
            byte_cnt_d = BW'(CTRL_WIDTH);
            state_d    = S_PKT;
          end
        end
      end
      S_PKT: begin
        if (wr_acc) begin
          push       = 1'b1;
          word_cnt_d = word_inc;
          if (io.in_ctrl == '0) begin
            byte_cnt_d = byte_body;
          end else begin
            byte_cnt_d      = byte_last;
            push_entry.miss = !hdr_vld_q;
            push_entry.err  = hdr_vld_q && mismatch;
            hdr_vld_d       = 1'b0;
            state_d         = S_HDR;
          end
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  assign head        = mem_q[rd_ptr_q];
  assign pop         = !reset && (cnt_q != 2'd0) && io.out_rdy;
  assign cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
  assign io.out_wr   = pop;
  assign io.out_data = head.data;
  assign io.out_ctrl = head.ctrl;
  assign pkt_done    = pop && (head.ctrl != '0);
  assign len_err     = pkt_done && head.err;
  assign hdr_missing = pkt_done && head.miss;
  assign src_port    = src_port_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      hdr_byte_q <= '0;
      hdr_word_q <= '0;
      src_port_q <= '0;
      hdr_vld_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      in_rdy_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      hdr_byte_q <= hdr_byte_d;
      hdr_word_q <= hdr_word_d;
      src_port_q <= src_port_d;
      hdr_vld_q  <= hdr_vld_d;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      cnt_q      <= cnt_d;
      in_rdy_q   <= (cnt_d < 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end
endmodule
